hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised data-hazard block for the integer pipeline. It tracks every in-flight register write from EX through the final writeback stage in an internal shift pipeline. It drives per-operand forwarding selects for the instruction in EX and a load-use / multi-cycle-result stall for the instruction in ID. It supersedes fixed two-stage forwarding: configurable depth, operand count and per-instruction result latency.

Parameters:
NUM_SRC, 2, source operands per instruction.
FWD_DEPTH, 2, tracked stages after EX (entry 0 = EX/MEM, entry FWD_DEPTH-1 = WB); min 1.
LAT_W, 2, width of result-latency field.
SEL_W, $clog2(FWD_DEPTH+1), forward-select width (derived, not overridable).

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous active-low reset.
hold  in  1  global freeze (memory wait); all state holds.
flush  in  1  squash instruction in ID (branch resolved in EX).
id_valid  in  1  ID holds a real instruction.
id_rs  in  NUM_SRC*5  ID source register addresses, operand s at [5s+4:5s].
id_rs_used  in  NUM_SRC  operand s actually read.
id_rd  in  5  ID destination register.
id_reg_write  in  1  ID instruction writes rd.
id_lat  in  LAT_W  entry index at which result becomes forwardable (0 = ALU, 1 = load, ...).
stall_o  out  1  hold IF/ID and insert bubble into EX.
fwd_sel  out  NUM_SRC*SEL_W  per EX operand: 0 = register file, k = entry k-1.

Behaviour:
- State: EX slot {valid, rs[NUM_SRC], rs_used, rd, we, lat}; entries[0..FWD_DEPTH-1] {valid, rd, we, lat}.
- Reset (rst_n=0 at clk edge): all valid bits 0; stall_o=0, fwd_sel=0 combinationally from reset state.
- Update priority per edge: reset > hold > normal. If hold: nothing changes.
- Normal: entries[i] <= entries[i-1]; entries[0] <= EX slot; EX slot <= bubble if (flush || stall_o || !id_valid), else ID fields.
- A producer matches operand rs when valid && we && rd != 0 && rd == rs. x0 never matches.
- fwd_sel[s] (combinational, EX slot): youngest (lowest i) matching entry gives i+1; none, or !rs_used[s], gives 0. Youngest-wins resolves double hazards.
- Entry i is ready when i >= lat. A non-ready youngest match on a used EX operand is illegal; SVA assertion, not handled in RTL.
- stall_o (combinational, ID): 1 if id_valid && !flush && any used id_rs[s] has youngest producer that will not be ready next cycle:
  - EX slot matching with lat > 0, or
  - entries[i] matching with lat > i+1.
  - Only the youngest producer per operand is checked.
- Matches older than entry FWD_DEPTH-1 are served by the register file. The register file is write-through; this block does not model it.
- Stall repeats each cycle until satisfied: load with lat=1 gives one cycle; lat=L gives L cycles back-to-back.
- flush during stall: stall_o drops the same cycle; EX slot becomes a bubble.
- hold during stall: stall_o stays asserted; state frozen.
- Outputs depend only on registered state plus ID inputs; no combinational path from fwd_sel to stall_o.

Optional Feature:
HAZ_PERF_CNT_EN: when defined, adds outputs stall_cnt[31:0] and fwd_cnt[31:0].
- stall_cnt increments on each non-hold cycle with stall_o=1.
- fwd_cnt increments on each non-hold cycle with EX slot valid and any fwd_sel[s] != 0.
- Both clear on reset and wrap at 2^32.
When undefined, the ports and counters are absent; remaining behaviour is identical.

Test Plan:
(Defaults NUM_SRC=2, FWD_DEPTH=2.)
1. ALU back-to-back: add x5 (lat0), then sub x6,x5,x1 -> stall_o=0; with sub in EX, fwd_sel[0]=1, fwd_sel[1]=0.
2. Distance-2 use: add x5; nop; or x7,x2,x5 -> in EX, fwd_sel[1]=2.
3. Load-use: lw x7 (lat1), then add x8,x7,x7 -> stall_o=1 for exactly one cycle, EX gets a bubble; add then enters EX with fwd_sel[0]=fwd_sel[1]=2.
4. Double hazard and x0: add x3; addi x3; sub x4,x3,x0 -> fwd_sel[0]=1 (youngest), fwd_sel[1]=0. A writer to x0 followed by a reader of x0 -> sel 0, no stall.
5. Flush/hold interaction:
   - lw x9 then use of x9 while stalled; flush=1 that cycle -> stall_o=0 same cycle, EX slot bubble next cycle.
   - Repeat with hold=1 for 3 cycles -> stall_o and fwd_sel constant across hold.
6. Reset mid-operation: rst_n=0 one edge with all entries valid -> next cycle stall_o=0, all fwd_sel=0; with HAZ_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_if
// Connects the hazard scoreboard to the ID/EX pipeline control.
//
// Signals:
//   hold, flush            pipeline control from the core (master -> slave)
//   id_valid, id_rs,       the instruction currently in ID (master -> slave)
//   id_rs_used, id_rd,
//   id_reg_write, id_lat
//   stall_o                freeze IF/ID and send a bubble to EX (slave -> master)
//   fwd_sel                per-operand forward select for EX (slave -> master)
//   stall_cnt, fwd_cnt     perf counters, present only with HAZ_PERF_CNT_EN
//
// Modports: master = pipeline side, slave = scoreboard side.
// Optional macro: HAZ_PERF_CNT_EN adds the counter signals.
// ----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LAT_W     = 2
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic                     hold;
    logic                     flush;
    logic                     id_valid;
    logic [NUM_SRC*5-1:0]     id_rs;
    logic [NUM_SRC-1:0]       id_rs_used;
    logic [4:0]               id_rd;
    logic                     id_reg_write;
    logic [LAT_W-1:0]         id_lat;
    logic                     stall_o;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]              stall_cnt;
    logic [31:0]              fwd_cnt;
`endif

    modport master (
        output hold, flush, id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_lat,
`ifdef HAZ_PERF_CNT_EN
        input  stall_cnt, fwd_cnt,
`endif
        input  stall_o, fwd_sel
    );

    modport slave (
        input  hold, flush, id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_lat,
`ifdef HAZ_PERF_CNT_EN
        output stall_cnt, fwd_cnt,
`endif
        output stall_o, fwd_sel
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks in-flight register writes from EX down to WB and produces:
//   - fwd_sel : per EX operand, 0 = register file, k = forward from entry k-1
//               (youngest matching producer wins)
//   - stall_o : load-use / multi-cycle-result stall for the instruction in ID
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    hazard_scoreboard_if.slave (ID fields, hold/flush, stall_o, fwd_sel)
//
// Parameters: NUM_SRC (operands/instr), FWD_DEPTH (tracked stages after EX,
// entry 0 = EX/MEM, entry FWD_DEPTH-1 = WB), LAT_W (latency field width).
// Optional macro: HAZ_PERF_CNT_EN adds 32-bit stall_cnt / fwd_cnt counters.
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LAT_W     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_scoreboard_if.slave bus
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    // EX slot
    logic                 ex_valid_q, ex_valid_d;
    logic [NUM_SRC*5-1:0] ex_rs_q, ex_rs_d;
    logic [NUM_SRC-1:0]   ex_used_q, ex_used_d;
    logic [4:0]           ex_rd_q, ex_rd_d;
    logic                 ex_we_q, ex_we_d;
    logic [LAT_W-1:0]     ex_lat_q, ex_lat_d;

    // Tracked stages after EX
    logic                 ent_valid_q [FWD_DEPTH];
    logic                 ent_we_q    [FWD_DEPTH];
    logic [4:0]           ent_rd_q    [FWD_DEPTH];
    logic [LAT_W-1:0]     ent_lat_q   [FWD_DEPTH];
    logic                 ent_valid_d [FWD_DEPTH];
    logic                 ent_we_d    [FWD_DEPTH];
    logic [4:0]           ent_rd_d    [FWD_DEPTH];
    logic [LAT_W-1:0]     ent_lat_d   [FWD_DEPTH];

    logic                     stall_c;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;
    logic [NUM_SRC-1:0]       fwd_notready;
    logic                     chk_found;
    logic                     chk_hazard;
    logic [4:0]               chk_rs;

    // x0 is hardwired zero, so a write to it never creates a dependency.
    function automatic logic producer_match(input logic v, input logic we,
                                            input logic [4:0] rd, input logic [4:0] rs);
        return v && we && (rd != 5'd0) && (rd == rs);
    endfunction

    // Forward selects for the EX operands. Scanning oldest to youngest lets the
    // youngest match overwrite older ones.
    always_comb begin
        fwd_sel_c    = '0;
        fwd_notready = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
                if (ex_used_q[s] &&
                    producer_match(ent_valid_q[i], ent_we_q[i], ent_rd_q[i], ex_rs_q[5*s +: 5])) begin
                    fwd_sel_c[SEL_W*s +: SEL_W] = SEL_W'(i + 1);
                    fwd_notready[s]             = int'(ent_lat_q[i]) > i;
                end
            end
        end
    end

    // Stall for the ID instruction. Only the youngest producer of each operand
    // matters: an older write to the same register is dead. The result must be
    // forwardable one cycle from now, i.e. at the producer's next position.
    always_comb begin
        stall_c    = 1'b0;
        chk_found  = 1'b0;
        chk_hazard = 1'b0;
        chk_rs     = 5'd0;
        for (int s = 0; s < NUM_SRC; s++) begin
            chk_rs     = bus.id_rs[5*s +: 5];
            chk_found  = 1'b0;
            chk_hazard = 1'b0;
            if (producer_match(ex_valid_q, ex_we_q, ex_rd_q, chk_rs)) begin
                chk_found  = 1'b1;
                chk_hazard = (ex_lat_q != '0);
            end
            for (int i = 0; i < FWD_DEPTH; i++) begin
                if (!chk_found &&
                    producer_match(ent_valid_q[i], ent_we_q[i], ent_rd_q[i], chk_rs)) begin
                    chk_found  = 1'b1;
                    chk_hazard = int'(ent_lat_q[i]) > (i + 1);
                end
            end
            if (bus.id_rs_used[s] && chk_hazard) begin
                stall_c = 1'b1;
            end
        end
        if (!bus.id_valid || bus.flush) begin
            stall_c = 1'b0;
        end
    end

    assign bus.stall_o = stall_c;
    assign bus.fwd_sel = fwd_sel_c;

    // EX slot next state: a bubble carries no valid, write or used bits.
    always_comb begin
        ex_valid_d = 1'b0;
        ex_rs_d    = '0;
        ex_used_d  = '0;
        ex_rd_d    = 5'd0;
        ex_we_d    = 1'b0;
        ex_lat_d   = '0;
        if (bus.id_valid && !bus.flush && !stall_c) begin
            ex_valid_d = 1'b1;
            ex_rs_d    = bus.id_rs;
            ex_used_d  = bus.id_rs_used;
            ex_rd_d    = bus.id_rd;
            ex_we_d    = bus.id_reg_write;
            ex_lat_d   = bus.id_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_rs_q    <= '0;
            ex_used_q  <= '0;
            ex_rd_q    <= 5'd0;
            ex_we_q    <= 1'b0;
            ex_lat_q   <= '0;
        end else if (!bus.hold) begin
            ex_valid_q <= ex_valid_d;
            ex_rs_q    <= ex_rs_d;
            ex_used_q  <= ex_used_d;
            ex_rd_q    <= ex_rd_d;
            ex_we_q    <= ex_we_d;
            ex_lat_q   <= ex_lat_d;
        end
    end

    // Shift pipeline: entry 0 takes the EX slot, entry i takes entry i-1.
    genvar gi;
    generate
        for (gi = 0; gi < FWD_DEPTH; gi++) begin : g_ent
            if (gi == 0) begin : g_head
                assign ent_valid_d[gi] = ex_valid_q;
                assign ent_we_d[gi]    = ex_we_q;
                assign ent_rd_d[gi]    = ex_rd_q;
                assign ent_lat_d[gi]   = ex_lat_q;
            end else begin : g_tail
                assign ent_valid_d[gi] = ent_valid_q[gi-1];
                assign ent_we_d[gi]    = ent_we_q[gi-1];
                assign ent_rd_d[gi]    = ent_rd_q[gi-1];
                assign ent_lat_d[gi]   = ent_lat_q[gi-1];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ent_valid_q[gi] <= 1'b0;
                    ent_we_q[gi]    <= 1'b0;
                    ent_rd_q[gi]    <= 5'd0;
                    ent_lat_q[gi]   <= '0;
                end else if (!bus.hold) begin
                    ent_valid_q[gi] <= ent_valid_d[gi];
                    ent_we_q[gi]    <= ent_we_d[gi];
                    ent_rd_q[gi]    <= ent_rd_d[gi];
                    ent_lat_q[gi]   <= ent_lat_d[gi];
                end
            end
        end
    endgenerate

    // A used EX operand must never depend on a producer whose result is not
    // yet forwardable; the stall logic is responsible for preventing it.
    a_fwd_ready: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(ex_valid_q && (|fwd_notready)));

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall_c};
        fwd_cnt_d   = fwd_cnt_q + {31'd0, (ex_valid_q && (|fwd_sel_c))};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            fwd_cnt_q   <= 32'd0;
        end else if (!bus.hold) begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard
// Directed pipeline sequences for hazard_scoreboard (NUM_SRC=2, FWD_DEPTH=2).
// Each cycle the stimulus pushes the expected stall/forward outputs into a
// queue; the checker pops them and compares against the DUT one step later.
// ----------------------------------------------------------------------------
module tb_hazard_scoreboard;
    localparam int NUM_SRC   = 2;
    localparam int FWD_DEPTH = 2;
    localparam int LAT_W     = 2;

    typedef struct packed {
        logic       stall;
        logic [1:0] s0;
        logic [1:0] s1;
    } exp_t;

    logic clk;
    logic rst_n;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks;
    int    n_err;

    hazard_scoreboard_if #(.NUM_SRC(NUM_SRC), .FWD_DEPTH(FWD_DEPTH), .LAT_W(LAT_W)) bus ();

    hazard_scoreboard #(.NUM_SRC(NUM_SRC), .FWD_DEPTH(FWD_DEPTH), .LAT_W(LAT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One pipeline cycle: drive ID, record expectation, compare, then clock.
    task automatic step(input string tag, input logic v,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] used,
                        input logic [4:0] rd, input logic we, input logic [1:0] lat,
                        input logic fl, input logic hd,
                        input logic es, input logic [1:0] e0, input logic [1:0] e1);
        exp_t  e;
        string t;
        bus.id_valid     = v;
        bus.id_rs        = {rs2, rs1};
        bus.id_rs_used   = used;
        bus.id_rd        = rd;
        bus.id_reg_write = we;
        bus.id_lat       = lat;
        bus.flush        = fl;
        bus.hold         = hd;
        exp_q.push_back('{stall: es, s0: e0, s1: e1});
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        $display("step %-14s stall=%0d sel=%0d/%0d", t, bus.stall_o, bus.fwd_sel[1:0], bus.fwd_sel[3:2]);
        check_val({t, "_stall"}, {31'd0, bus.stall_o}, {31'd0, e.stall});
        check_val({t, "_sel0"}, {30'd0, bus.fwd_sel[1:0]}, {30'd0, e.s0});
        check_val({t, "_sel1"}, {30'd0, bus.fwd_sel[3:2]}, {30'd0, e.s1});
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input string tag, input logic [1:0] e0, input logic [1:0] e1);
        step(tag, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, e0, e1);
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) nop("drain", 2'd0, 2'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.hold = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b0;
        bus.id_rs = '0; bus.id_rs_used = '0; bus.id_rd = '0;
        bus.id_reg_write = 1'b0; bus.id_lat = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state: even a real reader in ID sees nothing in flight.
        step("rst", 1'b1, 5'd5, 5'd6, 2'b11, 5'd7, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        rst_n = 1'b1;
        drain();
`ifdef HAZ_PERF_CNT_EN
        check_val("cnt_stall_rst", bus.stall_cnt, 32'd0);
        check_val("cnt_fwd_rst", bus.fwd_cnt, 32'd0);
`endif

        // 1. ALU back-to-back
        step("t1_add", 1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        step("t1_sub", 1, 5'd5, 5'd1, 2'b11, 5'd6, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        nop("t1_subEX", 2'd1, 2'd0);
        drain();

        // 2. Distance-2 use
        step("t2_add", 1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        nop("t2_gap", 2'd0, 2'd0);
        step("t2_or", 1, 5'd2, 5'd5, 2'b11, 5'd7, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        nop("t2_orEX", 2'd0, 2'd2);
        drain();

        // 3. Load-use, one stall cycle
        step("t3_lw", 1, 5'd1, 5'd0, 2'b01, 5'd7, 1, 2'd1, 0, 0, 0, 2'd0, 2'd0);
        step("t3_add_stall", 1, 5'd7, 5'd7, 2'b11, 5'd8, 1, 2'd0, 0, 0, 1, 2'd0, 2'd0);
        step("t3_add_go", 1, 5'd7, 5'd7, 2'b11, 5'd8, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        nop("t3_addEX", 2'd2, 2'd2);
        drain();

        // 4. Double hazard, then x0
        step("t4_add", 1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        step("t4_addi", 1, 5'd1, 5'd0, 2'b01, 5'd3, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        step("t4_sub", 1, 5'd3, 5'd0, 2'b11, 5'd4, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        nop("t4_subEX", 2'd1, 2'd0);
        drain();
        step("t4_wr_x0", 1, 5'd1, 5'd2, 2'b11, 5'd0, 1, 2'd1, 0, 0, 0, 2'd0, 2'd0);
        step("t4_rd_x0", 1, 5'd0, 5'd0, 2'b11, 5'd13, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        nop("t4_x0EX", 2'd0, 2'd0);
        drain();

        // 5a. Latency-2 load stalls twice
        step("t5_lw2", 1, 5'd1, 5'd0, 2'b01, 5'd9, 1, 2'd2, 0, 0, 0, 2'd0, 2'd0);
        step("t5_l2_st1", 1, 5'd9, 5'd0, 2'b01, 5'd10, 1, 2'd0, 0, 0, 1, 2'd0, 2'd0);
        step("t5_l2_st2", 1, 5'd9, 5'd0, 2'b01, 5'd10, 1, 2'd0, 0, 0, 1, 2'd0, 2'd0);
        step("t5_l2_go", 1, 5'd9, 5'd0, 2'b01, 5'd10, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        nop("t5_l2_EX", 2'd0, 2'd0);
        drain();

        // 5b. Flush while stalled drops stall and leaves a bubble
        step("t5_lwf", 1, 5'd1, 5'd0, 2'b01, 5'd9, 1, 2'd2, 0, 0, 0, 2'd0, 2'd0);
        step("t5_use_stall", 1, 5'd9, 5'd0, 2'b01, 5'd10, 1, 2'd0, 0, 0, 1, 2'd0, 2'd0);
        step("t5_use_flush", 1, 5'd9, 5'd0, 2'b01, 5'd10, 1, 2'd0, 1, 0, 0, 2'd0, 2'd0);
        nop("t5_bubble", 2'd0, 2'd0);
        drain();

        // 5c. Hold during stall freezes outputs
        step("t5_add_x1", 1, 5'd2, 5'd3, 2'b11, 5'd1, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        step("t5_lwh", 1, 5'd1, 5'd0, 2'b01, 5'd9, 1, 2'd1, 0, 0, 0, 2'd0, 2'd0);
        for (int k = 0; k < 3; k++)
            step("t5_hold", 1, 5'd9, 5'd0, 2'b01, 5'd10, 1, 2'd0, 0, 1, 1, 2'd1, 2'd0);
        step("t5_hold_rel", 1, 5'd9, 5'd0, 2'b01, 5'd10, 1, 2'd0, 0, 0, 1, 2'd1, 2'd0);
        step("t5_after", 1, 5'd9, 5'd0, 2'b01, 5'd10, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        nop("t5_useEX", 2'd2, 2'd0);
        drain();

        // 6. Reset with every slot valid
        step("t6_add10", 1, 5'd1, 5'd2, 2'b11, 5'd10, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        step("t6_add11", 1, 5'd1, 5'd2, 2'b11, 5'd11, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        step("t6_lw12", 1, 5'd11, 5'd0, 2'b01, 5'd12, 1, 2'd1, 0, 0, 0, 2'd0, 2'd0);
        rst_n = 1'b0;
        step("t6_in_rst", 1, 5'd12, 5'd11, 2'b11, 5'd13, 1, 2'd0, 0, 0, 1, 2'd1, 2'd0);
        rst_n = 1'b1;
        step("t6_post", 1, 5'd12, 5'd11, 2'b11, 5'd13, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
`ifdef HAZ_PERF_CNT_EN
        check_val("cnt_stall_post", bus.stall_cnt, 32'd0);
        check_val("cnt_fwd_post", bus.fwd_cnt, 32'd0);
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
